arbiter_req_frontend: RTL and testbench

Request front end for the 3-way arbiter. It synchronises and debounces three raw request inputs (board push-buttons or async client lines) and latches each press as a held request level on `x[2:0]`, which drives the arbiter's X2..X0 inputs. It watches the arbiter's registered state code `q[1:0]` and clears each latched request once that channel has been granted and its input released. It also flags stalled requests and presses that were lost while a request was outstanding.

---
 rtl/arbiter_req_frontend.sv | 211 +++++++++++++++++++++
 tb/tb_arbiter_req_frontend.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_req_frontend.sv
// ---------------------------------------------------------------------------
// arbiter_req_frontend
//
// Request front end for the 3-way arbiter. Each of the three raw request
// lines is synchronised, debounced and turned into a held request level on
// x[2:0]. A latched request is cleared once the arbiter has granted the
// channel and the debounced input has been released. Sticky flags report
// requests that waited too long (stall) and presses that arrived while a
// request was already outstanding (ovf).
//
// Parameters:
//   DEB_CYCLES  consecutive stable cycles before the debounced level moves
//               (1..255)
//   TIMEOUT     cycles a request may wait un-granted before stall sets
//               (1..65535)
//
// Ports:
//   clk    in   1  single clock, rising edge
//   rst    in   1  synchronous, active-high reset
//   btn    in   3  raw asynchronous requests, btn[i] belongs to channel i
//   q      in   2  arbiter state: 00 idle, 01 ch2, 10 ch1, 11 ch0 granted
//   x      out  3  registered request levels to the arbiter (X2..X0)
//   stall  out  3  sticky, request waited >= TIMEOUT cycles without grant
//   ovf    out  3  sticky, new press while the request was outstanding
// ---------------------------------------------------------------------------
module arbiter_req_frontend #(
  parameter int DEB_CYCLES = 4,
  parameter int TIMEOUT    = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn,
  input  logic [1:0] q,
  output logic [2:0] x,
  output logic [2:0] stall,
  output logic [2:0] ovf
);

  // Per-channel request FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_PEND  = 2'b01;
  localparam logic [1:0] ST_GRANT = 2'b10;

  // Arbiter grant codes as seen on q
  localparam logic [1:0] Q_GRANT_CH2 = 2'b01;
  localparam logic [1:0] Q_GRANT_CH1 = 2'b10;
  localparam logic [1:0] Q_GRANT_CH0 = 2'b11;

  localparam logic [7:0]  DEB_LAST   = 8'(DEB_CYCLES - 1);
  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT);

  // Synchroniser and debouncer state
  logic [2:0] s1_q, s1_d;
  logic [2:0] s2_q, s2_d;
  logic [2:0] deb_q, deb_d;
  logic [7:0] cnt_q [3];
  logic [7:0] cnt_d [3];

  // Request FSM and flag state
  logic [1:0]  state_q [3];
  logic [1:0]  state_d [3];
  logic [15:0] wcnt_q  [3];
  logic [15:0] wcnt_d  [3];
  logic [2:0]  x_q, x_d;
  logic [2:0]  stall_q, stall_d;
  logic [2:0]  ovf_q, ovf_d;

  // Combinational helpers
  logic [2:0] press_s;
  logic [2:0] g_s;

  // Two-flop synchroniser followed by the stable-count debouncer
  always_comb begin
    s1_d = btn;
    s2_d = s1_q;
    for (int i = 0; i < 3; i++) begin
      deb_d[i] = deb_q[i];
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] == DEB_LAST) begin
        // Input has disagreed with the debounced level long enough: follow it
        deb_d[i] = s2_q[i];
        cnt_d[i] = 8'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  // Press detection uses the next debounced level so the FSM reacts on the
  // same edge the debounced level rises
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      press_s[i] = ~deb_q[i] & deb_d[i];
    end
  end

  // Decode the arbiter state code into one grant bit per channel
  always_comb begin
    g_s[2] = (q == Q_GRANT_CH2);
    g_s[1] = (q == Q_GRANT_CH1);
    g_s[0] = (q == Q_GRANT_CH0);
  end

  // Per-channel request FSM plus overflow detection
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      ovf_d[i]   = ovf_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (press_s[i]) begin
            state_d[i] = ST_PEND;
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_PEND: begin
          // A release while pending leaves the request latched
          if (press_s[i]) begin
            ovf_d[i] = 1'b1;
          end else begin
            ovf_d[i] = ovf_q[i];
          end
          if (g_s[i]) begin
            state_d[i] = ST_GRANT;
          end else begin
            state_d[i] = ST_PEND;
          end
        end
        ST_GRANT: begin
          if (press_s[i]) begin
            // Released and pressed again during the grant: a new request
            ovf_d[i]   = 1'b1;
            state_d[i] = ST_PEND;
          end else if (!deb_d[i]) begin
            state_d[i] = ST_IDLE;
          end else if (!g_s[i]) begin
            // Grant withdrawn while the channel still requests
            state_d[i] = ST_PEND;
          end else begin
            state_d[i] = ST_GRANT;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
        end
      endcase
    end
  end

  // Request level, wait counter and stall flag
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      x_d[i] = (state_d[i] != ST_IDLE);

      // Counting only while staying in PEND makes every entry restart at 0
      if ((state_d[i] == ST_PEND) && (state_q[i] == ST_PEND)) begin
        if (wcnt_q[i] != WAIT_LIMIT) begin
          wcnt_d[i] = wcnt_q[i] + 16'd1;
        end else begin
          wcnt_d[i] = wcnt_q[i];
        end
      end else begin
        wcnt_d[i] = 16'd0;
      end

      if ((state_d[i] == ST_GRANT) && (state_q[i] != ST_GRANT)) begin
        stall_d[i] = 1'b0;
      end else if (wcnt_d[i] == WAIT_LIMIT) begin
        stall_d[i] = 1'b1;
      end else begin
        stall_d[i] = stall_q[i];
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 3'b000;
      s2_q    <= 3'b000;
      deb_q   <= 3'b000;
      x_q     <= 3'b000;
      stall_q <= 3'b000;
      ovf_q   <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i]   <= 8'd0;
        state_q[i] <= ST_IDLE;
        wcnt_q[i]  <= 16'd0;
      end
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      deb_q   <= deb_d;
      x_q     <= x_d;
      stall_q <= stall_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i]   <= cnt_d[i];
        state_q[i] <= state_d[i];
        wcnt_q[i]  <= wcnt_d[i];
      end
    end
  end

  assign x     = x_q;
  assign stall = stall_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_arbiter_req_frontend.sv
// Testbench for arbiter_req_frontend: directed scenarios followed by random
// button/grant traffic, checked every cycle against a behavioural model via
// an expectation queue.
module tb_arbiter_req_frontend;

  localparam int DEB = 4;
  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btn = 3'b000;
  logic [1:0] q   = 2'b00;
  logic [2:0] x, stall, ovf;

  always #5 clk = ~clk;

  arbiter_req_frontend #(.DEB_CYCLES(DEB), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .q     (q),
    .x     (x),
    .stall (stall),
    .ovf   (ovf)
  );

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] stall;
    logic [2:0] ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // ---------------- behavioural model ----------------
  // The debounced level follows the synchronised input once the last DEB
  // samples all disagree with it. A request is "held" from press until the
  // channel was granted and released; the wait is measured as elapsed edges.
  int          edge_no = 0;
  bit          m_s1[3], m_s2[3], m_deb[3];
  bit [DEB-1:0] m_hist[3];
  bit          m_held[3], m_gr[3], m_stall[3], m_ovf[3];
  int          m_start[3];

  task automatic model_edge(input logic r, input logic [2:0] b, input logic [1:0] qq);
    for (int ch = 0; ch < 3; ch++) begin
      bit deb_new, press, g;
      if (r) begin
        m_s1[ch] = 0; m_s2[ch] = 0; m_deb[ch] = 0; m_hist[ch] = '0;
        m_held[ch] = 0; m_gr[ch] = 0; m_stall[ch] = 0; m_ovf[ch] = 0;
        m_start[ch] = 0;
      end else begin
        m_hist[ch] = {m_hist[ch][DEB-2:0], m_s2[ch]};
        deb_new = m_deb[ch];
        if (m_hist[ch] == {DEB{~m_deb[ch]}}) deb_new = ~m_deb[ch];
        press = !m_deb[ch] && deb_new;
        g = (qq == 2'(3 - ch));
        if (!m_held[ch]) begin
          if (press) begin
            m_held[ch] = 1; m_gr[ch] = 0; m_start[ch] = edge_no;
          end
        end else if (!m_gr[ch]) begin
          if (press) m_ovf[ch] = 1;
          if (g) begin
            m_gr[ch] = 1; m_stall[ch] = 0;
          end
        end else begin
          if (press) begin
            m_ovf[ch] = 1; m_gr[ch] = 0; m_start[ch] = edge_no;
          end else if (!deb_new) begin
            m_held[ch] = 0; m_gr[ch] = 0;
          end else if (!g) begin
            m_gr[ch] = 0; m_start[ch] = edge_no;
          end
        end
        if (m_held[ch] && !m_gr[ch] && (edge_no - m_start[ch] >= TMO)) m_stall[ch] = 1;
        m_deb[ch] = deb_new;
        m_s2[ch]  = m_s1[ch];
        m_s1[ch]  = b[ch];
      end
    end
    edge_no++;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int ch = 0; ch < 3; ch++) begin
      e.x[ch]     = m_held[ch];
      e.stall[ch] = m_stall[ch];
      e.ovf[ch]   = m_ovf[ch];
    end
    return e;
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic [2:0] b, input logic [1:0] qq, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst = r; btn = b; q = qq;
      model_edge(r, b, qq);
      exp_q.push_back(model_out());
    end
  endtask

  // ---------------- monitor ----------------
  task automatic check(input string name, input logic [2:0] got, input logic [2:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s edge=%0d got=%b expected=%b", name, edge_no, got, want);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("x", x, e.x);
        check("stall", stall, e.stall);
        check("ovf", ovf, e.ovf);
      end
    end
  end

  initial begin
    int dur[3];
    int qdur;
    logic [2:0] b;
    logic [1:0] qq;

    // Reset with all buttons held, then release reset: fresh presses
    drive(1'b1, 3'b111, 2'b00, 2);
    drive(1'b0, 3'b111, 2'b00, 8);
    drive(1'b1, 3'b000, 2'b00, 2);
    drive(1'b0, 3'b000, 2'b00, 4);

    // Glitch filter on channel 1, then a real press
    drive(1'b0, 3'b010, 2'b00, 3);
    drive(1'b0, 3'b000, 2'b00, 8);
    drive(1'b0, 3'b010, 2'b00, 10);
    drive(1'b0, 3'b000, 2'b00, 8);
    drive(1'b1, 3'b000, 2'b00, 1);

    // Grant/release on channel 0
    drive(1'b0, 3'b001, 2'b00, 8);
    drive(1'b0, 3'b001, 2'b11, 5);
    drive(1'b0, 3'b000, 2'b11, 8);
    drive(1'b0, 3'b000, 2'b00, 4);

    // Withdrawn grant on channel 2
    drive(1'b0, 3'b100, 2'b00, 8);
    drive(1'b0, 3'b100, 2'b01, 3);
    drive(1'b0, 3'b100, 2'b00, 6);
    drive(1'b0, 3'b000, 2'b01, 8);
    drive(1'b1, 3'b000, 2'b00, 1);

    // Stall on channel 1, then grant clears it
    drive(1'b0, 3'b010, 2'b00, 30);
    drive(1'b0, 3'b010, 2'b10, 3);
    drive(1'b0, 3'b000, 2'b10, 8);
    drive(1'b0, 3'b000, 2'b00, 2);

    // Overflow on channel 1: release and re-press while pending
    drive(1'b0, 3'b010, 2'b00, 8);
    drive(1'b0, 3'b000, 2'b00, 8);
    drive(1'b0, 3'b010, 2'b00, 8);
    drive(1'b0, 3'b000, 2'b00, 10);

    // Random traffic
    b = 3'b000; qq = 2'b00; qdur = 1;
    for (int ch = 0; ch < 3; ch++) dur[ch] = 1;
    for (int t = 0; t < 1500; t++) begin
      for (int ch = 0; ch < 3; ch++) begin
        dur[ch]--;
        if (dur[ch] <= 0) begin
          b[ch] = ~b[ch];
          dur[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40))
                                                : int'($urandom_range(1, 12));
        end
      end
      qdur--;
      if (qdur <= 0) begin
        qq = 2'($urandom_range(0, 3));
        qdur = int'($urandom_range(1, 30));
      end
      drive(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0, b, qq, 1);
    end

    // Drain the expectation queue with a bounded wait
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain left=%0d expected=0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
